// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: load/store size encodings, LSU FSM states and size helpers
package riscv_lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   function automatic logic size_is_byte(input logic [2:0] size);
      return size == LDST_B || size == LDST_BU;
   endfunction

   function automatic logic size_is_half(input logic [2:0] size);
      return size == LDST_H || size == LDST_HU;
   endfunction

   // Unlisted encodings behave as words, so anything not byte/half is word-sized.
   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr);
      return size_is_half(size) ? addr[0] : !size_is_byte(size) && addr != 2'b00;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte-enable, store-lane replication and load extract/extend
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic        is_b, is_h, sx;
   logic [1:0]  off;
   logic [31:0] shifted;

   always_comb begin
      is_b      = size_is_byte(size);
      is_h      = size_is_half(size);
      sx        = ~size[2];
      off       = is_b ? addr : is_h ? {addr[1], 1'b0} : 2'b00;
      be        = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
      wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
      shifted   = rdata >> {off, 3'b000};
      rdata_ext = is_b ? {{24{sx & shifted[7]}}, shifted[7:0]}
                : is_h ? {{16{sx & shifted[15]}}, shifted[15:0]}
                : shifted;
   end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load-store unit with req/gnt/rvalid bus FSM; LSU_MISALIGN_TRAP_EN enables misaligned-access trapping
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [2:0]        lsu_size_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [31:0]       lsu_wdata_i,
   output logic              lsu_stall_req_o,
   output logic [31:0]       lsu_rdata_o,
   output logic              lsu_misalign_o,
   output logic              data_req_o,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [31:0]       data_wdata_o
);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [2:0]        size_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be;
   logic [31:0]       wdata_rep, rdata_ext;
   logic              trap;

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;
   assign trap = misaligned(lsu_size_i, lsu_addr_i[1:0]);
   always_ff @(posedge clk_i)
      mis_q <= rst_i ? 1'b0 : (state_q == IDLE) & lsu_req_i & trap;
   assign lsu_misalign_o = mis_q;
`else
   assign trap           = 1'b0;
   assign lsu_misalign_o = 1'b0;
`endif

   riscv_lsu_align u_align (
      .size      (size_q),
      .addr      (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     (data_rdata_i),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata_ext (rdata_ext)
   );

   assign lsu_stall_req_o = lsu_req_i & (state_q != DONE);

   always_comb begin
      state_d      = state_q;
      data_req_o   = 1'b0;
      data_we_o    = 1'b0;
      data_be_o    = '0;
      data_addr_o  = '0;
      data_wdata_o = '0;
      case (state_q)
         IDLE: state_d = lsu_req_i ? (trap ? DONE : REQ) : IDLE;
         REQ: begin
            data_req_o   = 1'b1;
            data_we_o    = we_q;
            data_be_o    = be;
            data_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
            data_wdata_o = wdata_rep;
            state_d      = data_gnt_i ? (we_q ? DONE : RESP) : REQ;
         end
         RESP:    state_d = data_rvalid_i ? DONE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         size_q      <= '0;
         wdata_q     <= '0;
         lsu_rdata_o <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && lsu_req_i) begin
            addr_q  <= lsu_addr_i;
            we_q    <= lsu_we_i;
            size_q  <= lsu_size_i;
            wdata_q <= lsu_wdata_i;
         end
         if (state_q == RESP && data_rvalid_i)
            lsu_rdata_o <= rdata_ext;
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized scoreboard bench for riscv_lsu against a byte-lane reference model
module tb_riscv_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lsu_req_i, lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic        lsu_stall_req_o, lsu_misalign_o;
   logic [31:0] lsu_rdata_o;
   logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
   logic [31:0] data_rdata_i, data_addr_o, data_wdata_o;
   logic [3:0]  data_be_o;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          stalls;
   } done_t;

   bus_t        bus_q[$];
   done_t       done_q[$];
   int          vectors = 0;
   int          errors = 0;
   int          stall_cnt = 0;
   logic [31:0] prev_rdata = '0;

   always #5 clk_i = ~clk_i;

   riscv_lsu #(.ADDR_W(32)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .lsu_req_i       (lsu_req_i),
      .lsu_we_i        (lsu_we_i),
      .lsu_size_i      (lsu_size_i),
      .lsu_addr_i      (lsu_addr_i),
      .lsu_wdata_i     (lsu_wdata_i),
      .lsu_stall_req_o (lsu_stall_req_o),
      .lsu_rdata_o     (lsu_rdata_o),
      .lsu_misalign_o  (lsu_misalign_o),
      .data_req_o      (data_req_o),
      .data_gnt_i      (data_gnt_i),
      .data_rvalid_i   (data_rvalid_i),
      .data_rdata_i    (data_rdata_i),
      .data_we_o       (data_we_o),
      .data_be_o       (data_be_o),
      .data_addr_o     (data_addr_o),
      .data_wdata_o    (data_wdata_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   function automatic int nbytes(input logic [2:0] s);
      return (s == 3'd0 || s == 3'd4) ? 1 : (s == 3'd1 || s == 3'd5) ? 2 : 4;
   endfunction

   function automatic logic [31:0] rep_model(input logic [31:0] wd, input int n);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
      return v;
   endfunction

   function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [2:0] s,
                                             input int n, input int off);
      logic [31:0] v, mask;
      v = rd >> (8 * off);
      if (n == 4) return v;
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if ((s == 3'd0 || s == 3'd1) && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int g, input int r);
      int   n_b, a2, off, n;
      logic trap;
      bus_t b;
      n_b = nbytes(size);
      a2  = int'(addr[1:0]);
      off = a2 - (a2 % n_b);
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (a2 % n_b) != 0;
`else
      trap = 1'b0;
`endif
      n = trap ? 1 : we ? g + 2 : g + r + 3;
      if (!trap) begin
         b.addr  = addr & 32'hFFFF_FFFC;
         b.we    = we;
         b.be    = 4'(((1 << n_b) - 1) << off);
         b.wdata = rep_model(wdata, n_b);
         bus_q.push_back(b);
         if (!we) prev_rdata = load_model(rdata, size, n_b, off);
      end
      done_q.push_back('{prev_rdata, trap, n});
      lsu_req_i   = 1'b1;
      lsu_we_i    = we;
      lsu_size_i  = size;
      lsu_addr_i  = addr;
      lsu_wdata_i = wdata;
      for (int c = 0; c <= n; c++) begin
         data_gnt_i    = !trap && c == g + 1;
         data_rvalid_i = !trap && !we && c == g + 2 + r;
         data_rdata_i  = data_rvalid_i ? rdata : $urandom;
         if (c > 0) begin
            lsu_we_i    = 1'($urandom);
            lsu_size_i  = 3'($urandom);
            lsu_addr_i  = $urandom;
            lsu_wdata_i = $urandom;
         end
         tick;
      end
      lsu_req_i     = 1'b0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
   endtask

   initial begin
      bus_t b;
      done_t d;
      forever begin
         @(negedge clk_i);
         if (rst_i) stall_cnt = 0;
         else begin
            if (data_req_o) begin
               if (bus_q.size() == 0) chk("bus_unexpected_req", 32'(data_req_o), 32'd0);
               else begin
                  b = bus_q[0];
                  chk("bus_addr", data_addr_o, b.addr);
                  chk("bus_we", 32'(data_we_o), 32'(b.we));
                  chk("bus_be", 32'(data_be_o), 32'(b.be));
                  chk("bus_wdata", data_wdata_o, b.wdata);
                  if (data_gnt_i) void'(bus_q.pop_front());
               end
            end
            if (lsu_req_i && !lsu_stall_req_o) begin
               if (done_q.size() == 0) chk("done_unexpected", 32'(lsu_stall_req_o), 32'd1);
               else begin
                  d = done_q.pop_front();
                  chk("load_rdata", lsu_rdata_o, d.rdata);
                  chk("misalign_pulse", 32'(lsu_misalign_o), 32'(d.mis));
                  chk("stall_cycles", 32'(stall_cnt), 32'(d.stalls));
               end
               stall_cnt = 0;
            end else begin
               if (lsu_req_i) stall_cnt++;
               chk("misalign_quiet", 32'(lsu_misalign_o), 32'd0);
            end
         end
      end
   end

   initial begin
      bus_t b;
      rst_i         = 1'b1;
      lsu_req_i     = 1'b0;
      lsu_we_i      = 1'b0;
      lsu_size_i    = '0;
      lsu_addr_i    = '0;
      lsu_wdata_i   = '0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = '0;
      tick;
      tick;
      chk("rst_stall_noreq", 32'(lsu_stall_req_o), 32'd0);
      chk("rst_data_req", 32'(data_req_o), 32'd0);
      chk("rst_data_we", 32'(data_we_o), 32'd0);
      chk("rst_data_be", 32'(data_be_o), 32'd0);
      chk("rst_data_addr", data_addr_o, 32'd0);
      chk("rst_data_wdata", data_wdata_o, 32'd0);
      chk("rst_rdata", lsu_rdata_o, 32'd0);
      chk("rst_misalign", 32'(lsu_misalign_o), 32'd0);
      lsu_req_i = 1'b1;
      #1;
      chk("rst_stall_req", 32'(lsu_stall_req_o), 32'd1);
      lsu_req_i = 1'b0;
      tick;
      rst_i = 1'b0;
      tick;

      run_txn(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
      run_txn(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0, 0);
      run_txn(1'b0, 3'd0, 32'h0000_0302, 32'h0, 32'h0080_0000, 0, 0);
      run_txn(1'b0, 3'd4, 32'h0000_0302, 32'h0, 32'h0080_0000, 0, 0);
      run_txn(1'b0, 3'd1, 32'h0000_0302, 32'h0, 32'h8001_0000, 0, 0);
      run_txn(1'b0, 3'd5, 32'h0000_0302, 32'h0, 32'h8001_0000, 0, 0);
      run_txn(1'b0, 3'd2, 32'h0000_0400, 32'h0, 32'h1234_5678, 4, 1);
      run_txn(1'b1, 3'd1, 32'h0000_0506, 32'hBEEF_1234, 32'h0, 4, 0);
      run_txn(1'b0, 3'd2, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0, 0);

      b.addr  = 32'h0000_0600;
      b.we    = 1'b0;
      b.be    = 4'b1111;
      b.wdata = 32'h0;
      bus_q.push_back(b);
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b0;
      lsu_size_i  = 3'd2;
      lsu_addr_i  = 32'h0000_0600;
      lsu_wdata_i = 32'h0;
      tick;
      data_gnt_i = 1'b1;
      tick;
      data_gnt_i = 1'b0;
      rst_i      = 1'b1;
      lsu_req_i  = 1'b0;
      tick;
      rst_i         = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h5A5A_5A5A;
      chk("midrst_data_req", 32'(data_req_o), 32'd0);
      tick;
      data_rvalid_i = 1'b0;
      chk("midrst_rdata", lsu_rdata_o, 32'd0);
      chk("midrst_data_req_late", 32'(data_req_o), 32'd0);
      chk("midrst_stall", 32'(lsu_stall_req_o), 32'd0);
      prev_rdata = '0;

      repeat (300) begin
         run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         repeat ($urandom_range(0, 2)) begin
            data_gnt_i    = 1'($urandom);
            data_rvalid_i = 1'($urandom);
            data_rdata_i  = $urandom;
            lsu_addr_i    = $urandom;
            tick;
         end
         data_gnt_i    = 1'b0;
         data_rvalid_i = 1'b0;
      end

      repeat (3) tick;
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      chk("done_q_drained", 32'(done_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
